// File: rtl/word_unpacker.sv
// word_unpacker: splits one IN_W-bit word into IN_W/OUT_W consecutive OUT_W-bit
// beats on a valid/ready stream, with out_last flagging the final beat.
// Optional build macro WORD_UNPACKER_MSB_FIRST_EN: emit the most-significant
// slice first instead of the default least-significant-first order.
// IN_W must be an integer multiple of OUT_W.
module word_unpacker #(
    parameter int IN_W  = 144,
    parameter int OUT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             busy
);

    localparam int BEATS = IN_W / OUT_W;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

    localparam logic IDLE = 1'b0;
    localparam logic SEND = 1'b1;

    logic             state_q, state_d;
    logic [IN_W-1:0]  hold_q, hold_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [OUT_W-1:0] out_data_q, out_data_d;
    logic             out_last_q, out_last_d;
    logic [CW-1:0]    sel_w;
    logic [OUT_W-1:0] slice_w [BEATS];

    // View the next hold value as an array of beats so the output mux is a plain index.
    for (genvar g = 0; g < BEATS; g++) begin : g_slice
        assign slice_w[g] = hold_d[g*OUT_W +: OUT_W];
    end

`ifdef WORD_UNPACKER_MSB_FIRST_EN
    assign sel_w = LAST - cnt_d;
`else
    assign sel_w = cnt_d;
`endif

    // Next-state logic: accept a word in IDLE, step through beats in SEND,
    // and chain straight into the next word when the last beat is taken.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    hold_d  = in_data;
                    cnt_d   = '0;
                    state_d = SEND;
                end
            end
            default: begin
                if (out_ready) begin
                    if (cnt_q == LAST) begin
                        if (in_valid) begin
                            hold_d = in_data;
                            cnt_d  = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
        endcase
        out_data_d = slice_w[sel_w];
        out_last_d = (state_d == SEND) && (cnt_d == LAST);
    end

    // State, hold and registered outputs; reset abandons any word in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            hold_q     <= '0;
            cnt_q      <= '0;
            out_data_q <= '0;
            out_last_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            cnt_q      <= cnt_d;
            out_data_q <= out_data_d;
            out_last_q <= out_last_d;
        end
    end

    // in_ready looks at out_ready combinationally so a new word can be taken
    // in the same cycle the last beat leaves, keeping the stream gap-free.
    assign in_ready  = reset && ((state_q == IDLE) || (out_last_q && out_ready));
    assign out_data  = out_data_q;
    assign out_valid = (state_q == SEND);
    assign out_last  = out_last_q;
    assign busy      = (state_q == SEND);

endmodule

// File: tb/tb_word_unpacker.sv
// Directed bench for word_unpacker: default 144/8 instance plus a 144/16 instance.
module tb_word_unpacker;

    logic         clk;
    logic         reset;
    logic [143:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic [7:0]   out_data;
    logic         out_valid;
    logic         out_ready;
    logic         out_last;
    logic         busy;

    logic [143:0] in_data2;
    logic         in_valid2;
    logic         in_ready2;
    logic [15:0]  out_data2;
    logic         out_valid2;
    logic         out_ready2;
    logic         out_last2;
    logic         busy2;

    int nvec = 0;
    int nerr = 0;

    word_unpacker #(.IN_W(144), .OUT_W(8)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last), .busy(busy)
    );

    word_unpacker #(.IN_W(144), .OUT_W(16)) dut16 (
        .clk(clk), .reset(reset), .in_data(in_data2), .in_valid(in_valid2), .in_ready(in_ready2),
        .out_data(out_data2), .out_valid(out_valid2), .out_ready(out_ready2), .out_last(out_last2), .busy(busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Word whose byte k (LSB first) is base+k.
    function automatic logic [143:0] mkw8(input logic [7:0] base);
        logic [143:0] w;
        w = '0;
        for (int k = 0; k < 18; k++) w[k*8 +: 8] = base + 8'(k);
        return w;
    endfunction

    // Word whose 16-bit slice k is k+1.
    function automatic logic [143:0] mkw16();
        logic [143:0] w;
        w = '0;
        for (int k = 0; k < 9; k++) w[k*16 +: 16] = 16'(k + 1);
        return w;
    endfunction

    // Expected byte on beat k of a mkw8(base) word.
    function automatic logic [7:0] eb(input logic [7:0] base, input int k);
`ifdef WORD_UNPACKER_MSB_FIRST_EN
        return base + 8'(17 - k);
`else
        return base + 8'(k);
`endif
    endfunction

    function automatic logic [15:0] eb16(input int k);
`ifdef WORD_UNPACKER_MSB_FIRST_EN
        return 16'(9 - k);
`else
        return 16'(k + 1);
`endif
    endfunction

    task automatic chk_idle(input string tag);
        chk({tag, "_vld"},  32'(out_valid), 32'd0);
        chk({tag, "_busy"}, 32'(busy),      32'd0);
        chk({tag, "_rdy"},  32'(in_ready),  32'd1);
    endtask

    initial begin
        int acc;
        int lasts;
        bit done;
        reset      = 1'b0;
        in_data    = '0;
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        in_data2   = '0;
        in_valid2  = 1'b0;
        out_ready2 = 1'b1;

        // Reset state of both instances
        @(negedge clk);
        chk("rst_vld",   32'(out_valid), 32'd0);
        chk("rst_busy",  32'(busy),      32'd0);
        chk("rst_last",  32'(out_last),  32'd0);
        chk("rst_data",  32'(out_data),  32'd0);
        chk("rst_rdy",   32'(in_ready),  32'd0);
        chk("rst16_vld", 32'(out_valid2), 32'd0);
        chk("rst16_rdy", 32'(in_ready2),  32'd0);
        reset = 1'b1;
        @(negedge clk);
        chk_idle("post_rst");

        // Scenario 1: single word, no backpressure
        in_data  = mkw8(8'h01);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = '0;
        for (int k = 0; k < 18; k++) begin
            if (k > 0) @(negedge clk);
            chk("s1_vld",  32'(out_valid), 32'd1);
            chk("s1_busy", 32'(busy),      32'd1);
            chk("s1_data", 32'(out_data),  32'(eb(8'h01, k)));
            chk("s1_last", 32'(out_last),  32'(k == 17));
            chk("s1_rdy",  32'(in_ready),  32'(k == 17));
        end
        @(negedge clk);
        chk_idle("s1_end");

        // Scenario 2: out_ready pattern 1,0,0,1 repeating
        in_data  = mkw8(8'h01);
        in_valid = 1'b1;
        acc  = 0;
        done = 1'b0;
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clk);
            in_valid  = 1'b0;
            out_ready = ((c % 4) == 0) || ((c % 4) == 3);
            #1;
            chk("s2_vld", 32'(out_valid), 32'd1);
            chk("s2_data", 32'(out_data), 32'(eb(8'h01, acc)));
            chk("s2_last", 32'(out_last), 32'(acc == 17));
            chk("s2_rdy", 32'(in_ready), 32'((acc == 17) && out_ready));
            if (out_valid && out_ready) begin
                if (acc == 17) done = 1'b1;
                acc++;
            end
        end
        chk("s2_count", 32'(acc), 32'd18);
        out_ready = 1'b1;
        @(negedge clk);
        chk_idle("s2_end");

        // Scenario 3: back-to-back words A then B
        in_data  = mkw8(8'hA0);
        in_valid = 1'b1;
        lasts    = 0;
        @(negedge clk);
        in_data = mkw8(8'hC0);
        for (int k = 0; k < 36; k++) begin
            if (k > 0) @(negedge clk);
            if (k == 18) in_valid = 1'b0;
            #1;
            chk("s3_vld",  32'(out_valid), 32'd1);
            chk("s3_data", 32'(out_data),  32'((k < 18) ? eb(8'hA0, k) : eb(8'hC0, k - 18)));
            chk("s3_last", 32'(out_last),  32'((k == 17) || (k == 35)));
            chk("s3_rdy",  32'(in_ready),  32'((k == 17) || (k == 35)));
            if (out_last) lasts++;
        end
        chk("s3_lasts", 32'(lasts), 32'd2);
        @(negedge clk);
        chk_idle("s3_end");

        // Scenario 4: asynchronous reset in the middle of a word
        in_data  = mkw8(8'h30);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (k > 0) @(negedge clk);
            chk("s4_data", 32'(out_data), 32'(eb(8'h30, k)));
        end
        #2;
        reset = 1'b0;
        #1;
        chk("s4_vld",  32'(out_valid), 32'd0);
        chk("s4_busy", 32'(busy),      32'd0);
        chk("s4_last", 32'(out_last),  32'd0);
        chk("s4_rdy",  32'(in_ready),  32'd0);
        chk("s4_data0", 32'(out_data), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk_idle("s4_after");
        end

        // Scenario 6: 16-bit beats, nine slices 0x0001..0x0009
        in_data2  = mkw16();
        in_valid2 = 1'b1;
        #1;
        chk("s6_rdy0", 32'(in_ready2), 32'd1);
        @(negedge clk);
        in_valid2 = 1'b0;
        for (int k = 0; k < 9; k++) begin
            if (k > 0) @(negedge clk);
            chk("s6_vld",  32'(out_valid2), 32'd1);
            chk("s6_data", 32'(out_data2),  32'(eb16(k)));
            chk("s6_last", 32'(out_last2),  32'(k == 8));
        end
        @(negedge clk);
        chk("s6_end_vld", 32'(out_valid2), 32'd0);
        chk("s6_end_rdy", 32'(in_ready2),  32'd1);
        chk("s6_end_busy", 32'(busy2),     32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
